ram_channel_arbiter: RTL
========================

# ram_channel_arbiter

Parametrised multi-channel front end for the single-port RAM interface. It accepts independent read/write requests from NCH requesters (caches, DMA, debug port), grants one at a time under round-robin, and drives the cpu modport of the RAM interface (memREN/memWEN/memaddr/memstore out, ramstate/ramload in). Relative to the single-master interface it adds:

- request latching,
- per-channel completion/error handshakes,
- fairness,
- a bus-hang timeout.

## Interface
Parameters:
- NCH, 2, number of requester channels (≥1)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max ACTIVE cycles without ACCESS/ERROR before abort; 0 disables

Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  asynchronous active-low reset

Channel side:
- ch_ren  in  NCH  per-channel read request
- ch_wen  in  NCH  per-channel write request
- ch_addr  in  NCH*AW  channel i at [i*AW +: AW]
- ch_store  in  NCH*DW  channel i write data at [i*DW +: DW]
- ch_done  out  NCH  one-cycle completion pulse
- ch_err  out  NCH  qualifies ch_done: access failed or timed out
- ch_load  out  NCH*DW  read data, valid while ch_done[i]

RAM side:
- memREN  out  1  RAM read enable
- memWEN  out  1  RAM write enable
- memaddr  out  AW  RAM address
- memstore  out  DW  RAM write data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR from cpu_types_pkg
- ramload  in  DW  RAM read data

## Operation
- FSM states: IDLE, ACTIVE, RELEASE. All outputs are registered.
- Reset (async, nRST=0) drives all outputs to 0 and sets state=IDLE, rr_ptr=0, tmo_cnt=0, grant=0. This holds in any state, including mid-access.
- IDLE:
  - A channel requests if ch_ren[i]|ch_wen[i].
  - Grant goes to the first requesting channel scanning rr_ptr, rr_ptr+1, … mod NCH.
  - On grant: latch index g, addr, store, op. Op is write if ch_wen[g], else read; wen wins when both are set.
  - Next state is ACTIVE, with memWEN or memREN set (exactly one), memaddr/memstore from the latch.
  - No request: stay IDLE, mem* = 0.
- ACTIVE:
  - mem* hold the latched values. Channel inputs are ignored; a withdrawn request does not cancel the access.
  - ramstate==ACCESS: go to RELEASE with ch_done[g]=1, ch_err[g]=0. For reads, ch_load[g]=ramload sampled that edge; for writes, ch_load[g]=0.
  - ramstate==ERROR: go to RELEASE with ch_done[g]=1, ch_err[g]=1, ch_load[g]=0.
  - Otherwise (FREE/BUSY): tmo_cnt increments. If TIMEOUT≠0 and tmo_cnt reaches TIMEOUT, abort and go to RELEASE with done+err as for ERROR.
  - In every exit from ACTIVE, mem* clear to 0, tmo_cnt clears, and rr_ptr = (g+1) mod NCH.
- RELEASE:
  - Lasts one cycle. ch_done/ch_err/ch_load[g] are valid and mem*=0. No arbitration happens in this cycle.
  - Next state is IDLE; done/err/load clear to 0.
  - The requester must drop or replace its request by the end of RELEASE. A request still high in IDLE is a new access.
- At most one bit of ch_done is ever set.
- Every ch_load slice except the one of g in RELEASE reads 0.
- NCH=1: rr_ptr is constant 0.

## Timing
- Request sampled at edge k (IDLE) → mem* asserted in cycle k+1 (ACTIVE).
- ACCESS in the first ACTIVE cycle → ch_done high in cycle k+2 → IDLE in cycle k+3.
- Minimum request-to-done is 2 cycles. Maximum back-to-back throughput is one access per 3 cycles.
- Each BUSY/FREE cycle in ACTIVE adds one cycle of latency.
- Timeout abort: done appears in the cycle after the TIMEOUT-th consecutive non-ACCESS/non-ERROR ACTIVE cycle.
- ramstate/ramload are sampled only in ACTIVE. ACCESS seen in IDLE or RELEASE is ignored.
- Fairness: with all NCH channels continuously requesting, each channel is served exactly once per NCH accesses.

## Test plan
- Single read: ch0 ren, addr=0x40; RAM returns ACCESS in the first ACTIVE cycle with ramload=0xDEADBEEF → memREN=1 with memaddr=0x40 for exactly 1 cycle, then ch_done[0]=1 with ch_load slice 0 = 0xDEADBEEF 2 cycles after sampling, ch_err[0]=0.
- Contention, NCH=2: ch0 and ch1 both requesting from reset, held asserted → grant order ch0, ch1, ch0, ch1; each done spaced 3 cycles apart with RAM always ACCESS.
- Read and write both set: ch1 ren=wen=1, store=0x12345678 → memWEN=1, memREN=0, memstore=0x12345678; ch_load slice 1 = 0 on done.
- Timeout, TIMEOUT=4: RAM held BUSY → 4 ACTIVE cycles, then ch_done=ch_err=1 for the granted channel; memREN=0; next request arbitrated normally.
- RAM ERROR on the second ACTIVE cycle → done+err next cycle; rr_ptr advances; withdrawing the request mid-ACTIVE does not shorten or cancel the access.
- Reset mid-ACTIVE: nRST low asynchronously → all mem*, ch_done, ch_err, ch_load at 0 immediately. After release, the first grant goes to ch0 (rr_ptr=0).

Source files
------------

// File: rtl/ram_channel_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg: RAM handshake states seen on the cpu side of the RAM.
//
// ram_channel_arbiter: round-robin front end that lets NCH requesters share
// the single-port RAM interface. Each request is latched into the RAM
// outputs, held until the RAM answers (ACCESS/ERROR) or the bus-hang timeout
// expires, and then reported back on that channel as a one-cycle done pulse.
//
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   ch_ren / ch_wen    per-channel read / write request (write wins if both)
//   ch_addr / ch_store per-channel address / write data, channel i at [i*W +: W]
//   ch_done / ch_err   one-cycle completion pulse, err qualifies failure
//   ch_load            read data of the completing channel, else 0
//   memREN / memWEN    RAM enables (at most one set)
//   memaddr / memstore RAM address / write data
//   ramstate / ramload RAM status and read data
// ---------------------------------------------------------------------------
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;
endpackage

module ram_channel_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NCH-1:0]    ch_ren,
    input  logic [NCH-1:0]    ch_wen,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_store,
    output logic [NCH-1:0]    ch_done,
    output logic [NCH-1:0]    ch_err,
    output logic [NCH*DW-1:0] ch_load,
    output logic              memREN,
    output logic              memWEN,
    output logic [AW-1:0]     memaddr,
    output logic [DW-1:0]     memstore,
    input  ramstate_t         ramstate,
    input  logic [DW-1:0]     ramload
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Count value on the last permitted waiting cycle; the abort fires there.
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};
    localparam logic [GW-1:0] LAST_CH  = GW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ACTIVE  = 2'b01,
        S_RELEASE = 2'b10
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [GW-1:0]     gnt_r, gnt_nxt_s;
    logic [GW-1:0]     rr_ptr_r, rr_ptr_nxt_s;
    logic [TW-1:0]     tmo_cnt_r, tmo_cnt_nxt_s;
    logic [NCH-1:0]    req_s;
    logic [GW-1:0]     pick_s;
    logic              pick_vld_s;
    logic              hit_s, fail_s, tmo_s, exit_s;
    logic              mem_ren_nxt_s, mem_wen_nxt_s;
    logic [AW-1:0]     mem_addr_nxt_s;
    logic [DW-1:0]     mem_store_nxt_s;
    logic [NCH-1:0]    ch_done_nxt_s, ch_err_nxt_s;
    logic [NCH*DW-1:0] ch_load_nxt_s;

    // Channel index base+off taken modulo NCH (off < NCH).
    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NCH) begin
            sum = sum - NCH;
        end else begin
            sum = sum + 0;
        end
        return GW'(sum);
    endfunction

    // Round-robin scan: walk from the highest offset down so the requester
    // closest to rr_ptr is the one left in pick_s.
    always_comb begin
        req_s      = ch_ren | ch_wen;
        pick_s     = {GW{1'b0}};
        pick_vld_s = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            pick_s     = req_s[wrap_idx(rr_ptr_r, k)] ? wrap_idx(rr_ptr_r, k) : pick_s;
            pick_vld_s = pick_vld_s | req_s[wrap_idx(rr_ptr_r, k)];
        end
    end

    // ACTIVE exit conditions; the timeout only counts non-terminal RAM states.
    always_comb begin
        hit_s  = (ramstate == ACCESS);
        fail_s = (ramstate == ERROR);
        tmo_s  = (TIMEOUT != 0) && (tmo_cnt_r == TMO_LAST) && !hit_s && !fail_s;
        exit_s = hit_s | fail_s | tmo_s;
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE:    state_nxt_s = pick_vld_s ? S_ACTIVE : S_IDLE;
            S_ACTIVE:  state_nxt_s = exit_s ? S_RELEASE : S_ACTIVE;
            S_RELEASE: state_nxt_s = S_IDLE;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output logic: next values of every registered output and of the
    // grant/pointer/timeout bookkeeping. The RAM output registers double as
    // the request latch while ACTIVE.
    always_comb begin
        gnt_nxt_s       = gnt_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        tmo_cnt_nxt_s   = {TW{1'b0}};
        mem_ren_nxt_s   = 1'b0;
        mem_wen_nxt_s   = 1'b0;
        mem_addr_nxt_s  = {AW{1'b0}};
        mem_store_nxt_s = {DW{1'b0}};
        ch_done_nxt_s   = {NCH{1'b0}};
        ch_err_nxt_s    = {NCH{1'b0}};
        ch_load_nxt_s   = {(NCH*DW){1'b0}};
        case (state_r)
            S_IDLE: begin
                if (pick_vld_s) begin
                    gnt_nxt_s       = pick_s;
                    mem_wen_nxt_s   = ch_wen[pick_s];
                    mem_ren_nxt_s   = ~ch_wen[pick_s];
                    mem_addr_nxt_s  = ch_addr[pick_s*AW +: AW];
                    mem_store_nxt_s = ch_store[pick_s*DW +: DW];
                end else begin
                    gnt_nxt_s = gnt_r;
                end
            end
            S_ACTIVE: begin
                if (exit_s) begin
                    ch_done_nxt_s[gnt_r] = 1'b1;
                    ch_err_nxt_s[gnt_r]  = ~hit_s;
                    ch_load_nxt_s[gnt_r*DW +: DW] = (hit_s && memREN) ? ramload : {DW{1'b0}};
                    rr_ptr_nxt_s = (gnt_r == LAST_CH) ? {GW{1'b0}} : gnt_r + {{(GW-1){1'b0}}, 1'b1};
                end else begin
                    mem_ren_nxt_s   = memREN;
                    mem_wen_nxt_s   = memWEN;
                    mem_addr_nxt_s  = memaddr;
                    mem_store_nxt_s = memstore;
                    tmo_cnt_nxt_s   = tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            S_RELEASE: begin
                gnt_nxt_s = gnt_r;
            end
            default: begin
                gnt_nxt_s = gnt_r;
            end
        endcase
    end

    // Registered outputs and arbitration bookkeeping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            gnt_r     <= {GW{1'b0}};
            rr_ptr_r  <= {GW{1'b0}};
            tmo_cnt_r <= {TW{1'b0}};
            memREN    <= 1'b0;
            memWEN    <= 1'b0;
            memaddr   <= {AW{1'b0}};
            memstore  <= {DW{1'b0}};
            ch_done   <= {NCH{1'b0}};
            ch_err    <= {NCH{1'b0}};
            ch_load   <= {(NCH*DW){1'b0}};
        end else begin
            gnt_r     <= gnt_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
            memREN    <= mem_ren_nxt_s;
            memWEN    <= mem_wen_nxt_s;
            memaddr   <= mem_addr_nxt_s;
            memstore  <= mem_store_nxt_s;
            ch_done   <= ch_done_nxt_s;
            ch_err    <= ch_err_nxt_s;
            ch_load   <= ch_load_nxt_s;
        end
    end

endmodule
